// File: rtl/iter_mdu.sv
`default_nettype none
// ============================================================================
// Module   : iter_mdu
// Purpose  : Iterative multiply/divide unit. One radix-2 shift-add (multiply)
//            or restoring-division step per clock on operand magnitudes, with
//            sign correction applied once at the end. Division by zero and
//            signed overflow (MIN / -1) skip iteration and finish at once.
// Ports    : clk        - clock, all state changes on rising edge
//            rst        - synchronous active-high reset
//            flush      - abort any in-flight operation
//            in_valid   - request present       in_ready  - can accept
//            op[2:0]    - MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//            src1/src2  - multiplicand/dividend, multiplier/divisor
//            out_valid  - result present        out_ready - result taken
//            result     - operation result
// Revision : 1.0 - initial release
// ============================================================================
module iter_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] c_OP_MUL    = 3'b000;
  localparam logic [2:0] c_OP_MULH   = 3'b001;
  localparam logic [2:0] c_OP_MULHSU = 3'b010;
  localparam logic [2:0] c_OP_MULHU  = 3'b011;
  localparam logic [2:0] c_OP_DIV    = 3'b100;
  localparam logic [2:0] c_OP_DIVU   = 3'b101;
  localparam logic [2:0] c_OP_REM    = 3'b110;
  localparam logic [2:0] c_OP_REMU   = 3'b111;

  localparam logic [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_opb;   // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] r_hi;    // product high half / partial remainder
  logic [WIDTH-1:0] r_lo;    // multiplier bits / dividend bits -> quotient
  logic             r_neg;   // product or quotient must be negated
  logic             r_rneg;  // remainder must be negated

  // ---------------- request decode ----------------
  logic             w_s1_signed;
  logic             w_s2_signed;
  logic             w_s1_neg;
  logic             w_s2_neg;
  logic [WIDTH-1:0] w_s1_mag;
  logic [WIDTH-1:0] w_s2_mag;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH-1:0] w_special_res;

  assign w_s1_signed = (op == c_OP_MUL) || (op == c_OP_MULH) || (op == c_OP_MULHSU) ||
                       (op == c_OP_DIV) || (op == c_OP_REM);
  assign w_s2_signed = (op == c_OP_MUL) || (op == c_OP_MULH) ||
                       (op == c_OP_DIV) || (op == c_OP_REM);
  assign w_s1_neg    = w_s1_signed && src1[WIDTH-1];
  assign w_s2_neg    = w_s2_signed && src2[WIDTH-1];
  // Negating MIN yields MIN, which read unsigned is the correct magnitude.
  assign w_s1_mag    = w_s1_neg ? -src1 : src1;
  assign w_s2_mag    = w_s2_neg ? -src2 : src2;

  assign w_div0 = op[2] && (src2 == '0);
  // op[0]==0 among division ops selects the signed variants (DIV, REM).
  assign w_ovf  = op[2] && !op[0] && (src1 == c_MIN) && (src2 == '1);
  // op[1] distinguishes remainder from quotient.
  assign w_special_res = w_div0 ? (op[1] ? src1 : '1)
                                : (op[1] ? '0   : src1);

  // ---------------- iteration datapath ----------------
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rsh;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_rsh = {r_hi, r_lo[WIDTH-1]};
  assign w_ge  = (w_rsh >= {1'b0, r_opb});
  // Only taken when w_ge, so the difference always fits in WIDTH bits.
  assign w_sub = w_rsh[WIDTH-1:0] - r_opb;

  // ---------------- final sign correction ----------------
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_final;

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;
  assign w_quo      = r_neg ? -r_lo : r_lo;
  assign w_rem      = r_rneg ? -r_hi : r_hi;

  always_comb begin
    w_final = '0;
    case (r_op)
      c_OP_MUL:                           w_final = w_prod_fix[WIDTH-1:0];
      c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_final = w_prod_fix[2*WIDTH-1:WIDTH];
      c_OP_DIV, c_OP_DIVU:                w_final = w_quo;
      c_OP_REM, c_OP_REMU:                w_final = w_rem;
      default:                            w_final = '0;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_opb       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_neg       <= 1'b0;
      r_rneg      <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op       <= op;
            r_in_ready <= 1'b0;
            if (w_div0 || w_ovf) begin
              r_result    <= w_special_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_opb   <= op[2] ? w_s2_mag : w_s1_mag;
              r_lo    <= op[2] ? w_s1_mag : w_s2_mag;
              r_hi    <= '0;
              r_neg   <= w_s1_neg ^ w_s2_neg;
              r_rneg  <= w_s1_neg;
              r_cnt   <= '0;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == CW'(WIDTH)) begin
            r_result    <= w_final;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (r_op[2]) begin
              r_hi <= w_ge ? w_sub : w_rsh[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end else begin
              r_hi <= w_sum[WIDTH:1];
              r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_iter_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_mdu
// Purpose  : Self-checking bench for iter_mdu (WIDTH=32): directed vector
//            table, handshake/flush/reset sequences, and random operations
//            checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_mdu;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  int n_chk = 0;
  int n_err = 0;

  iter_mdu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .src1     (src1),
    .src2     (src2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the operation definitions.
  function automatic logic special_case(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 32'd0) || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (o)
      3'd0: begin p = sa * sb;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Presents a request and returns after the accepting edge (+1).
  task automatic accept(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("in_ready_timeout", 64'(in_ready), 64'd1);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); src1 = $urandom; src2 = $urandom;
  endtask

  // lat = edges after the accepting edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_release"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  task automatic run_and_check(input string name, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    accept(o, a, b);
    wait_valid(lat);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_res"}, 64'(result), 64'(exp));
    release_result(name);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", {30'd0, in_ready, out_valid, result}, {30'd0, 1'b1, 1'b0, 32'd0});

    // Normal ops finish 33 edges after acceptance; divide-by-zero and signed
    // overflow go straight to DONE, visible right after the accepting edge.
    vecs[0]  = '{"mul_3_m4",      3'd0, 32'd3,        32'hFFFFFFFC, 32'hFFFFFFF4, 33};
    vecs[1]  = '{"mulh_min_min",  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{"mulhu_max",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{"mulhsu_max",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{"divu_7_0",      3'd5, 32'd7,        32'd0,        32'hFFFFFFFF, 0};
    vecs[5]  = '{"rem_m7_0",      3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 0};
    vecs[6]  = '{"div_ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    vecs[7]  = '{"rem_ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0};
    vecs[8]  = '{"div_m7_2",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[9]  = '{"rem_m7_2",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[10] = '{"divu_100_7",    3'd5, 32'd100,      32'd7,        32'd14,       33};
    vecs[11] = '{"remu_100_7",    3'd7, 32'd100,      32'd7,        32'd2,        33};
    vecs[12] = '{"div_0_0",       3'd4, 32'd0,        32'd0,        32'hFFFFFFFF, 0};
    vecs[13] = '{"remu_5_0",      3'd7, 32'd5,        32'd0,        32'd5,        0};
    vecs[14] = '{"divu_min_m1",   3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
    vecs[15] = '{"mul_min_m1",    3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};

    for (int i = 0; i < 16; i++)
      run_and_check(vecs[i].name, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Backpressure: DONE holds with in_valid pending; release returns to
    // IDLE without accepting that pending request in the same cycle.
    accept(3'd5, 32'd100, 32'd7);
    wait_valid(lat);
    check("bp_lat", 64'(lat), 64'd33);
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; src1 = 32'd9; src2 = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {30'd0, in_ready, out_valid, result}, {30'd0, 1'b0, 1'b1, 32'd14});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_release", {62'd0, in_ready, out_valid}, 64'd2);

    // Flush mid-DIV: back to IDLE, result never presented.
    accept(3'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {62'd0, in_ready, out_valid}, 64'd2);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_valid", 64'(seen), 64'd0);

    // Flush coincident with a request accepts nothing.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; src1 = 32'd2; src2 = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_with_req", {62'd0, in_ready, out_valid}, 64'd2);

    // Reset 5 edges into a MUL clears everything, including the held result.
    accept(3'd0, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy", {30'd0, in_ready, out_valid, result}, {30'd0, 1'b1, 1'b0, 32'd0});
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst_no_valid", 64'(seen), 64'd0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = rand_operand();
      rb = rand_operand();
      run_and_check($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), ro, ra, rb,
                    ref_model(ro, ra, rb), special_case(ro, ra, rb) ? 0 : 33);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
